snake_dir_input: RTL and testbench

- Input-conditioning stage directly upstream of the graphics/game logic; drives its up/down/left/right inputs.
- Synchronises and debounces four raw push-buttons, then detects press edges.
- Holds a pending turn request and commits it only on the game's move tick.
- Rejects 180-degree reversals and repeated presses of the current direction.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 80 ++++++++
 rtl/snake_dir_input.sv | 137 +++++++++++++
 tb/tb_snake_dir_input.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared direction definitions for the snake direction input stage.
//   - DIR_UP / DIR_DOWN / DIR_LEFT / DIR_RIGHT : 2-bit direction codes
//   - dir_reverse() : opposite direction (codes are paired so the low bit flips)
//   - dir_onehot()  : 4-bit one-hot decode, bit index equals the direction code
//                     (bit0=up, bit1=down, bit2=left, bit3=right)
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0, so flipping it reverses.
    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'b01;
    endfunction

    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        case (d)
            DIR_UP:    oh = 4'b0001;
            DIR_DOWN:  oh = 4'b0010;
            DIR_LEFT:  oh = 4'b0100;
            DIR_RIGHT: oh = 4'b1000;
            default:   oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: two-flop synchroniser, consecutive-mismatch
// debounce counter, stable level, and a registered one-cycle press pulse on
// each rising edge of the stable level. Releases produce no pulse.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   btn    : raw active-high button, asynchronous to clk
//   press  : one-cycle pulse, one cycle after the stable level rises
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    // Terminal count: the stable level flips on the DEBOUNCE_CYCLES-th
    // consecutive mismatched cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_r;
    logic             s2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
        end
    end

    // Debounce: count consecutive cycles that disagree with the stable level;
    // any agreeing cycle restarts the count, so bounce never qualifies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (s2_r != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= s2_r;
                    cnt_r    <= {CNT_W{1'b0}};
                end else begin
                    stable_r <= stable_r;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
            end else begin
                stable_r <= stable_r;
                cnt_r    <= {CNT_W{1'b0}};
            end
        end
    end

    // Rising-edge detect of the stable level, registered into a press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/snake_dir_input.sv
// -----------------------------------------------------------------------------
// snake_dir_input
// Turns four raw direction buttons into the committed snake heading.
// Each button is synchronised, debounced and edge-detected; the highest
// priority press (UP > DOWN > LEFT > RIGHT) becomes the pending turn if it is
// neither the current heading nor its reverse. The pending turn is committed
// on move_tick.
//
// Ports:
//   clk          : system clock (shared with the graphics/game logic)
//   reset        : asynchronous active-low reset
//   btn_up/down/left/right : raw active-high buttons
//   move_tick    : one-cycle pulse marking a snake step
//   dir          : committed direction code (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   up/down/left/right : registered one-hot decode of dir
//   dir_changed  : one-cycle pulse when a commit changed dir
// -----------------------------------------------------------------------------
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         CNT_W           = 20,
    parameter logic [1:0] RESET_DIR       = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_tick,
    output logic [1:0] dir,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       dir_changed
);

    // Bit index of each vector equals the direction code.
    logic [3:0] btn_raw_s;
    logic [3:0] press_s;

    logic       req_valid_s;
    dir_t       req_dir_s;
    dir_t       commit_nxt_s;
    logic       accept_s;
    dir_t       pending_nxt_s;

    dir_t       committed_r;
    dir_t       pending_r;
    logic [3:0] onehot_r;
    logic       dir_changed_r;

    assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw_s[g]),
            .press (press_s[g])
        );
    end

    // Fixed-priority pick of one press per cycle; losers are dropped.
    always_comb begin
        req_valid_s = 1'b0;
        req_dir_s   = DIR_UP;
        if (press_s[0]) begin
            req_valid_s = 1'b1;
            req_dir_s   = DIR_UP;
        end else if (press_s[1]) begin
            req_valid_s = 1'b1;
            req_dir_s   = DIR_DOWN;
        end else if (press_s[2]) begin
            req_valid_s = 1'b1;
            req_dir_s   = DIR_LEFT;
        end else if (press_s[3]) begin
            req_valid_s = 1'b1;
            req_dir_s   = DIR_RIGHT;
        end else begin
            req_valid_s = 1'b0;
            req_dir_s   = DIR_UP;
        end
    end

    // Heading after this cycle's commit; requests are judged against it,
    // never against pending, so two quick turns cannot add up to a reversal.
    always_comb begin
        commit_nxt_s = committed_r;
        if (move_tick) begin
            commit_nxt_s = pending_r;
        end else begin
            commit_nxt_s = committed_r;
        end
    end

    // Accept a turn only if it is a genuine 90-degree change; last one wins.
    always_comb begin
        accept_s      = req_valid_s
                        && (req_dir_s != commit_nxt_s)
                        && (req_dir_s != dir_reverse(commit_nxt_s));
        pending_nxt_s = pending_r;
        if (accept_s) begin
            pending_nxt_s = req_dir_s;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Pending/committed heading registers and registered output decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            committed_r   <= RESET_DIR;
            pending_r     <= RESET_DIR;
            onehot_r      <= dir_onehot(RESET_DIR);
            dir_changed_r <= 1'b0;
        end else begin
            committed_r   <= commit_nxt_s;
            pending_r     <= pending_nxt_s;
            onehot_r      <= dir_onehot(commit_nxt_s);
            dir_changed_r <= move_tick && (pending_r != committed_r);
        end
    end

    assign dir         = committed_r;
    assign up          = onehot_r[0];
    assign down        = onehot_r[1];
    assign left        = onehot_r[2];
    assign right       = onehot_r[3];
    assign dir_changed = dir_changed_r;

endmodule

// File: tb/tb_snake_dir_input.sv
// -----------------------------------------------------------------------------
// tb_snake_dir_input
// Self-checking bench for snake_dir_input with DEBOUNCE_CYCLES=4, CNT_W=3.
// A behavioural model (delay line of raw samples, mismatch run lengths, press
// events, heading rules) is stepped on every rising edge; DUT outputs are
// compared on the falling edge. Directed scenarios are followed by random
// button/tick/reset traffic.
// -----------------------------------------------------------------------------
module tb_snake_dir_input;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btn_v;       // bit0=up, bit1=down, bit2=left, bit3=right
    logic       move_tick;
    logic [1:0] dir;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       dir_changed;

    int n_checks;
    int n_pass;

    // Reference model state
    int       m_comm;
    int       m_pend;
    bit       m_chg;
    bit [3:0] m_h1;          // raw sample taken at the last edge
    bit [3:0] m_h2;          // raw sample taken two edges ago
    bit [3:0] m_stab;
    int       m_run [4];
    bit [3:0] m_rise_prev;   // stable rose at the previous edge
    bit [3:0] m_press;       // press events visible to the arbiter this edge

    snake_dir_input #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .RESET_DIR       (2'd3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_v[0]),
        .btn_down    (btn_v[1]),
        .btn_left    (btn_v[2]),
        .btn_right   (btn_v[3]),
        .move_tick   (move_tick),
        .dir         (dir),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .dir_changed (dir_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        int       win;
        int       r;
        bit [3:0] rise;
        if (!reset) begin
            m_comm      = 3;
            m_pend      = 3;
            m_chg       = 1'b0;
            m_h1        = 4'b0;
            m_h2        = 4'b0;
            m_stab      = 4'b0;
            m_rise_prev = 4'b0;
            m_press     = 4'b0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
        end else begin
            win = -1;
            for (int b = 3; b >= 0; b--) begin
                if (m_press[b]) win = b;
            end
            r      = move_tick ? m_pend : m_comm;
            m_chg  = move_tick && (m_pend != m_comm);
            m_comm = r;
            if (win >= 0 && win != r && win != (r ^ 1)) m_pend = win;

            rise = 4'b0;
            for (int b = 0; b < 4; b++) begin
                if (m_h2[b] != m_stab[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_stab[b] = m_h2[b];
                        m_run[b]  = 0;
                        rise[b]   = m_stab[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_press     = m_rise_prev;
            m_rise_prev = rise;
            m_h2        = m_h1;
            m_h1        = btn_v;
        end
    endtask

    // One clock: model on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("dir", 32'(dir), 32'(m_comm));
        chk("onehot", 32'({right, left, down, up}), 32'(4'b0001 << m_comm));
        chk("dir_changed", 32'(dir_changed), 32'(m_chg));
    endtask

    task automatic hold(input logic [3:0] m, input int n);
        btn_v = m;
        repeat (n) step();
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        btn_v     = 4'b0;
        move_tick = 1'b0;

        // Reset state and idle ticks
        do_reset();
        chk("rst_dir", 32'(dir), 32'd3);
        chk("rst_right", 32'(right), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_tick_chg", 32'(dir_changed), 32'd0);
            step();
        end

        // UP held, then commit
        hold(4'b0001, 10);
        hold(4'b0000, 2);
        tick();
        chk("up_dir", 32'(dir), 32'd0);
        chk("up_onehot", 32'(up), 32'd1);
        chk("up_chg", 32'(dir_changed), 32'd1);
        step();
        chk("up_chg_pulse", 32'(dir_changed), 32'd0);

        // Bouncing UP never qualifies
        do_reset();
        for (int i = 0; i < 5; i++) begin
            hold(4'b0001, 2);
            hold(4'b0000, 2);
        end
        hold(4'b0000, 4);
        tick();
        chk("bounce_dir", 32'(dir), 32'd3);
        chk("bounce_chg", 32'(dir_changed), 32'd0);

        // Reversal rejected; reverse of committed refused after a valid turn
        hold(4'b0100, 8);
        hold(4'b0000, 4);
        tick();
        chk("rev_dir", 32'(dir), 32'd3);
        hold(4'b0001, 8);
        hold(4'b0000, 4);
        hold(4'b0100, 8);
        hold(4'b0000, 4);
        tick();
        chk("dbl_turn_dir", 32'(dir), 32'd0);
        chk("dbl_turn_chg", 32'(dir_changed), 32'd1);

        // Simultaneous LEFT and RIGHT: LEFT wins
        hold(4'b1100, 8);
        hold(4'b0000, 4);
        tick();
        chk("prio_dir", 32'(dir), 32'd2);

        // DOWN pending, reset while held, re-qualifies afterwards
        hold(4'b0010, 8);
        do_reset();
        step();
        chk("rst_mid_dir", 32'(dir), 32'd3);
        chk("rst_mid_chg", 32'(dir_changed), 32'd0);
        hold(4'b0010, D + 5);
        tick();
        chk("requal_dir", 32'(dir), 32'd1);
        hold(4'b0000, 4);

        // Random traffic
        for (int seg = 0; seg < 400; seg++) begin
            logic [3:0] mask;
            int         len;
            mask = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 12);
            btn_v = mask;
            for (int c = 0; c < len; c++) begin
                move_tick = ($urandom_range(0, 5) == 0);
                reset     = ($urandom_range(0, 299) != 0);
                step();
            end
        end
        move_tick = 1'b0;
        reset     = 1'b1;
        btn_v     = 4'b0000;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
